// File: rtl/lob_pkg.sv
// Shared opcodes, response codes, widths and scheduler state encodings
// for the limit-order-book command path.
package lob_pkg;

    localparam int ORDER_W   = 48;
    localparam int ID_W      = 16;
    localparam int SUCCESS_W = 16;
    localparam int CMD_W     = 2 + ID_W + ORDER_W;

    localparam logic [1:0] CMD_ADD  = 2'b00;
    localparam logic [1:0] CMD_EXEC = 2'b01;

    localparam logic [1:0] RSP_OK       = 2'b00;
    localparam logic [1:0] RSP_NOT_DONE = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT  = 2'b10;
    localparam logic [1:0] RSP_BAD      = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_RELEASE,
        ST_RESP
    } sched_state_t;

    function automatic logic cmd_is_valid(input logic [1:0] cmd_type);
        return (cmd_type == CMD_ADD) || (cmd_type == CMD_EXEC);
    endfunction

endpackage

// File: rtl/order_cmd_fifo.sv
// Synchronous command FIFO with count-based full/empty flags and
// a combinational read of the head entry.
module order_cmd_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/order_cmd_scheduler.sv
// Serialises parser commands onto the add and execute engines, which share
// the order RAMs, using a start/done handshake guarded by a timeout.
module order_cmd_scheduler
    import lob_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                TMO_W      = 16,
    parameter logic [TMO_W-1:0]  TIMEOUT    = TMO_W'(20000)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_type,
    input  logic [ID_W-1:0]      cmd_id,
    input  logic [ORDER_W-1:0]   cmd_order,
    output logic                 add_start,
    output logic [ORDER_W-1:0]   add_order,
    input  logic                 add_done,
    input  logic [SUCCESS_W-1:0] add_success,
    output logic                 exec_start,
    output logic [ID_W-1:0]      exec_id,
    input  logic                 exec_done,
    input  logic [SUCCESS_W-1:0] exec_success,
    output logic                 ram_owner,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [1:0]           rsp_code
);

    localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - TMO_W'(1);

    sched_state_t         state_q;
    logic [1:0]           cur_type_q;
    logic [ID_W-1:0]      cur_id_q;
    logic [ORDER_W-1:0]   cur_order_q;
    logic                 add_start_q;
    logic                 exec_start_q;
    logic                 ram_owner_q;
    logic                 rsp_valid_q;
    logic [1:0]           code_q;
    logic [TMO_W-1:0]     cnt_q;
    logic [TMO_W-1:0]     cnt_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_push;
    logic [CMD_W-1:0]     fifo_rdata;

    logic                 load_owner;
    logic                 other_done;
    logic                 sel_done;
    logic [SUCCESS_W-1:0] sel_success;
    logic                 tmo_hit;

    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    order_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i ({cmd_type, cmd_id, cmd_order}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign load_owner  = (cur_type_q == CMD_EXEC);
    assign other_done  = load_owner ? add_done : exec_done;
    assign sel_done    = ram_owner_q ? exec_done : add_done;
    assign sel_success = ram_owner_q ? exec_success : add_success;
    assign tmo_hit     = (cnt_q >= TMO_LAST);
    assign cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);

    // LOAD waits for the other engine's done to clear so a start never
    // rises against a stale done from the previous owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cur_type_q   <= '0;
            cur_id_q     <= '0;
            cur_order_q  <= '0;
            add_start_q  <= 1'b0;
            exec_start_q <= 1'b0;
            ram_owner_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            code_q       <= RSP_OK;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {cur_type_q, cur_id_q, cur_order_q} <= fifo_rdata;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!cmd_is_valid(cur_type_q)) begin
                        code_q      <= RSP_BAD;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        ram_owner_q <= load_owner;
                        if (!other_done) begin
                            add_start_q  <= !load_owner;
                            exec_start_q <= load_owner;
                            cnt_q        <= '0;
                            state_q      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (sel_done) begin
                        code_q       <= (sel_success == '0) ? RSP_NOT_DONE : RSP_OK;
                        add_start_q  <= 1'b0;
                        exec_start_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= ST_RELEASE;
                    end else if (tmo_hit) begin
                        code_q       <= RSP_TIMEOUT;
                        add_start_q  <= 1'b0;
                        exec_start_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RELEASE: begin
                    if (!sel_done || tmo_hit) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = !fifo_full;
    assign add_start  = add_start_q;
    assign add_order  = cur_order_q;
    assign exec_start = exec_start_q;
    assign exec_id    = cur_id_q;
    assign ram_owner  = ram_owner_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = cur_id_q;
    assign rsp_code   = code_q;

endmodule

// File: tb/tb_order_cmd_scheduler.sv
// Scoreboard bench for order_cmd_scheduler: directed commands push expected
// responses, monitors pop and compare on every rsp_valid strobe.
module tb_order_cmd_scheduler;

    typedef struct {
        logic [15:0] id;
        logic [1:0]  code;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdType;
    logic [15:0] cmdId;
    logic [47:0] cmdOrder;
    logic        addStart;
    logic [47:0] addOrder;
    logic        addDone;
    logic [15:0] addSuccess;
    logic        execStart;
    logic [15:0] execId;
    logic        execDone;
    logic [15:0] execSuccess;
    logic        ramOwner;
    logic        busy;
    logic        rspValid;
    logic [15:0] rspId;
    logic [1:0]  rspCode;

    logic        cmdValidB;
    logic        cmdReadyB;
    logic [1:0]  cmdTypeB;
    logic [15:0] cmdIdB;
    logic [47:0] cmdOrderB;
    logic        addStartB;
    logic [47:0] addOrderB;
    logic        addDoneB;
    logic [15:0] addSuccessB;
    logic        execStartB;
    logic [15:0] execIdB;
    logic        execDoneB;
    logic [15:0] execSuccessB;
    logic        ramOwnerB;
    logic        busyB;
    logic        rspValidB;
    logic [15:0] rspIdB;
    logic [1:0]  rspCodeB;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        expA[$];
    exp_t        expB[$];
    exp_t        eA;
    exp_t        eB;

    int          addLat = 3;
    int          execLat = 3;
    logic        addHold = 1'b0;
    logic        execHold = 1'b0;
    logic [15:0] addSuccVal = 16'd1;
    logic [15:0] execSuccVal = 16'd1;
    int          addCnt;
    int          execCnt;

    int          lastRspCyc = 0;
    int          startRises = 0;
    int          overlapBad = 0;
    int          execHighB = 0;
    logic        prevAdd = 1'b0;
    logic        prevExec = 1'b0;

    order_cmd_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmdValid),
        .cmd_ready    (cmdReady),
        .cmd_type     (cmdType),
        .cmd_id       (cmdId),
        .cmd_order    (cmdOrder),
        .add_start    (addStart),
        .add_order    (addOrder),
        .add_done     (addDone),
        .add_success  (addSuccess),
        .exec_start   (execStart),
        .exec_id      (execId),
        .exec_done    (execDone),
        .exec_success (execSuccess),
        .ram_owner    (ramOwner),
        .busy         (busy),
        .rsp_valid    (rspValid),
        .rsp_id       (rspId),
        .rsp_code     (rspCode)
    );

    order_cmd_scheduler #(
        .FIFO_DEPTH (4),
        .TMO_W      (16),
        .TIMEOUT    (16'd16)
    ) dutTmo (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmdValidB),
        .cmd_ready    (cmdReadyB),
        .cmd_type     (cmdTypeB),
        .cmd_id       (cmdIdB),
        .cmd_order    (cmdOrderB),
        .add_start    (addStartB),
        .add_order    (addOrderB),
        .add_done     (addDoneB),
        .add_success  (addSuccessB),
        .exec_start   (execStartB),
        .exec_id      (execIdB),
        .exec_done    (execDoneB),
        .exec_success (execSuccessB),
        .ram_owner    (ramOwnerB),
        .busy         (busyB),
        .rsp_valid    (rspValidB),
        .rsp_id       (rspIdB),
        .rsp_code     (rspCodeB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign addSuccess   = addSuccVal;
    assign execSuccess  = execSuccVal;
    assign addSuccessB  = 16'h0003;
    assign execSuccessB = 16'h0000;
    assign execDoneB    = 1'b0;

    // Engine models: done rises addLat/execLat cycles after start, is held
    // until start falls, and may be stalled with the hold flags.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            addDone <= 1'b0;
            addCnt  <= 0;
        end else if (addStart) begin
            if (!addDone && !addHold) begin
                if (addCnt + 1 >= addLat) addDone <= 1'b1;
                else                      addCnt  <= addCnt + 1;
            end
        end else begin
            addDone <= 1'b0;
            addCnt  <= 0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            execDone <= 1'b0;
            execCnt  <= 0;
        end else if (execStart) begin
            if (!execDone && !execHold) begin
                if (execCnt + 1 >= execLat) execDone <= 1'b1;
                else                        execCnt  <= execCnt + 1;
            end
        end else begin
            execDone <= 1'b0;
            execCnt  <= 0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) addDoneB <= 1'b0;
        else      addDoneB <= addStartB;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (addStart && !prevAdd)   startRises++;
            if (execStart && !prevExec) startRises++;
            if ((addStart && execStart) || (addStart && !prevAdd && execDone) ||
                (execStart && !prevExec && addDone))
                overlapBad++;
            prevAdd  = addStart;
            prevExec = execStart;
            if (rspValid) begin
                lastRspCyc = cyc;
                if (expA.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL rspA unexpected: id=0x%0h code=%0d, none expected", rspId, rspCode);
                end else begin
                    eA = expA.pop_front();
                    checkOutput("rspA id", 64'(rspId), 64'(eA.id));
                    checkOutput("rspA code", 64'(rspCode), 64'(eA.code));
                end
            end
        end else begin
            prevAdd  = 1'b0;
            prevExec = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (execStartB) execHighB++;
            if (rspValidB) begin
                if (expB.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL rspB unexpected: id=0x%0h code=%0d, none expected", rspIdB, rspCodeB);
                end else begin
                    eB = expB.pop_front();
                    checkOutput("rspB id", 64'(rspIdB), 64'(eB.id));
                    checkOutput("rspB code", 64'(rspCodeB), 64'(eB.code));
                end
            end
        end
    end

    function automatic exp_t mkExp(input logic [15:0] id, input logic [1:0] code);
        exp_t e;
        e.id   = id;
        e.code = code;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    // with cmdValid still high so pushes can run back-to-back.
    task automatic applyStimulus(input logic [1:0] t, input logic [15:0] id,
                                 input logic [47:0] ord, output int acceptCyc);
        int guard = 0;
        cmdValid = 1'b1;
        cmdType  = t;
        cmdId    = id;
        cmdOrder = ord;
        while (!cmdReady && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("[TB] FAIL accept id=0x%0h: cmd_ready stayed 0 for %0d cycles, required 1", id, guard);
        end
        acceptCyc = cyc;
        @(negedge clk);
    endtask

    task automatic endPush();
        cmdValid = 1'b0;
    endtask

    task automatic waitDrainA(input int bound);
        int guard = 0;
        while ((expA.size() != 0 || busy) && guard < bound) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drainA pending", 64'(expA.size()), 64'd0);
    endtask

    task automatic waitStart(input logic isExec, input int bound, output int seenCyc);
        int guard = 0;
        while (!(isExec ? execStart : addStart) && guard < bound) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= bound) begin
            total++;
            bad++;
            $display("[TB] FAIL start wait: start not seen in %0d cycles, required high", bound);
        end
        seenCyc = cyc;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        int seen;
        int idBad;
        int guard;
        int risesBefore;

        rst = 1'b0;
        cmdValid = 1'b0; cmdType = '0; cmdId = '0; cmdOrder = '0;
        cmdValidB = 1'b0; cmdTypeB = '0; cmdIdB = '0; cmdOrderB = '0;
        repeat (3) @(negedge clk);

        checkOutput("reset cmd_ready", 64'(cmdReady), 64'd1);
        checkOutput("reset starts", 64'({addStart, execStart}), 64'd0);
        checkOutput("reset rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("reset busy/owner", 64'({busy, ramOwner}), 64'd0);
        checkOutput("reset cmd_ready B", 64'(cmdReadyB), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] test 1: ADD with 3-cycle engine");
        addLat = 3; addSuccVal = 16'd1;
        expA.push_back(mkExp(16'h0005, 2'b00));
        applyStimulus(2'b00, 16'h0005, 48'h0005_0064_000A, acc);
        endPush();
        waitStart(1'b0, 20, seen);
        checkOutput("add_start latency", 64'(seen - acc), 64'd3);
        checkOutput("ram_owner add", 64'(ramOwner), 64'd0);
        checkOutput("add_order", 64'(addOrder), 64'h0005_0064_000A);
        waitDrainA(100);

        $display("[TB] test 2: EXEC returning success=0 after 21 cycles");
        execLat = 21; execSuccVal = 16'd0;
        expA.push_back(mkExp(16'h0007, 2'b01));
        applyStimulus(2'b01, 16'h0007, 48'h0, acc);
        endPush();
        waitStart(1'b1, 20, seen);
        checkOutput("ram_owner exec", 64'(ramOwner), 64'd1);
        idBad = 0;
        guard = 0;
        while (execStart && guard < 100) begin
            if (execId !== 16'h0007) idBad++;
            @(negedge clk);
            guard++;
        end
        checkOutput("exec_id unstable cycles", 64'(idBad), 64'd0);
        waitDrainA(100);

        $display("[TB] test 3: invalid command type");
        risesBefore = startRises;
        expA.push_back(mkExp(16'h0009, 2'b11));
        applyStimulus(2'b10, 16'h0009, 48'h0, acc);
        endPush();
        waitDrainA(50);
        checkOutput("bad cmd response latency", 64'(lastRspCyc - acc), 64'd3);
        checkOutput("bad cmd start pulses", 64'(startRises - risesBefore), 64'd0);

        $display("[TB] test 4: EXEC timeout with TIMEOUT=16");
        expB.push_back(mkExp(16'h00A1, 2'b10));
        expB.push_back(mkExp(16'h00A2, 2'b00));
        cmdValidB = 1'b1; cmdTypeB = 2'b01; cmdIdB = 16'h00A1; cmdOrderB = 48'h0;
        @(negedge clk);
        cmdTypeB = 2'b00; cmdIdB = 16'h00A2; cmdOrderB = 48'h00A2_0010_0001;
        @(negedge clk);
        cmdValidB = 1'b0;
        guard = 0;
        while (!execStartB && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("B exec_start seen", 64'(execStartB), 64'd1);
        checkOutput("B exec_id", 64'(execIdB), 64'h00A1);
        checkOutput("B ram_owner", 64'(ramOwnerB), 64'd1);
        guard = 0;
        while ((expB.size() != 0 || busyB) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drainB pending", 64'(expB.size()), 64'd0);
        checkOutput("B exec_start high cycles", 64'(execHighB), 64'd16);
        checkOutput("B add_order", 64'(addOrderB), 64'h00A2_0010_0001);

        $display("[TB] test 5: FIFO fill behind a stalled engine");
        addLat = 1; addSuccVal = 16'd1; execLat = 2; execSuccVal = 16'd1;
        addHold = 1'b1;
        expA.push_back(mkExp(16'h0010, 2'b00));
        applyStimulus(2'b00, 16'h0010, 48'h0010_0001_0001, acc);
        endPush();
        waitStart(1'b0, 20, seen);
        expA.push_back(mkExp(16'h0011, 2'b00));
        applyStimulus(2'b00, 16'h0011, 48'h0011_0002_0002, acc);
        expA.push_back(mkExp(16'h0012, 2'b00));
        applyStimulus(2'b01, 16'h0012, 48'h0, acc);
        expA.push_back(mkExp(16'h0013, 2'b00));
        applyStimulus(2'b00, 16'h0013, 48'h0013_0003_0003, acc);
        expA.push_back(mkExp(16'h0014, 2'b00));
        applyStimulus(2'b01, 16'h0014, 48'h0, acc);
        checkOutput("cmd_ready after 4 accepts", 64'(cmdReady), 64'd0);
        expA.push_back(mkExp(16'h0015, 2'b00));
        fork
            applyStimulus(2'b00, 16'h0015, 48'h0015_0004_0004, acc);
            begin
                repeat (5) @(negedge clk);
                addHold = 1'b0;
            end
        join
        endPush();
        waitDrainA(500);
        checkOutput("start overlap events", 64'(overlapBad), 64'd0);

        $display("[TB] test 6: reset during exec dispatch");
        execHold = 1'b1;
        applyStimulus(2'b01, 16'h0020, 48'h0, acc);
        applyStimulus(2'b00, 16'h0021, 48'h0021_0005_0005, acc);
        endPush();
        waitStart(1'b1, 20, seen);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("async reset starts", 64'({addStart, execStart}), 64'd0);
        checkOutput("async reset rsp/owner/busy", 64'({rspValid, ramOwner, busy}), 64'd0);
        checkOutput("async reset rsp_id/code", 64'({rspId, rspCode}), 64'd0);
        checkOutput("async reset add_order/exec_id", 64'({addOrder, execId}), 64'd0);
        checkOutput("async reset cmd_ready", 64'(cmdReady), 64'd1);
        execHold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        addLat = 2; addSuccVal = 16'h0042;
        expA.push_back(mkExp(16'h0022, 2'b00));
        applyStimulus(2'b00, 16'h0022, 48'h0022_0006_0006, acc);
        endPush();
        waitDrainA(100);
        repeat (5) @(negedge clk);
        checkOutput("final overlap events", 64'(overlapBad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
